inst_rom_arbiter: RTL



---
 rtl/inst_rom_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the single combinational instruction ROM port between IF fetch and a debug reader.
// Fetch has priority; an anti-starvation counter forces a debug slot after MAX_WAIT denials.
module inst_rom_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned ROM_AW   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic        if_err_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_gnt_o,
  output logic        dbg_valid_o,
  output logic [31:0] dbg_inst_o,
  output logic        dbg_err_o,
  output logic [31:0] rom_a_o,
  input  logic [31:0] rom_inst_i
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic        if_valid_q, dbg_valid_q;
  logic [31:0] if_inst_q, dbg_inst_q;
  logic        if_err_q, dbg_err_q;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic        f_req, d_req, dbg_win;
  logic        addr_err;
  logic [31:0] rom_data;

  always_comb begin
    f_req     = if_req_i & ~if_flush_i & ~rst;
    d_req     = dbg_req_i & ~rst;
    // Debug wins when alone, or when it has waited its full budget.
    dbg_win   = d_req & (~f_req | (wait_cnt_q == MaxWait));
    dbg_gnt_o = dbg_win;
    if_gnt_o  = f_req & ~dbg_win;

    rom_a_o = 32'h0;
    if (if_gnt_o) begin
      rom_a_o = if_addr_i;
    end else if (dbg_gnt_o) begin
      rom_a_o = dbg_addr_i;
    end

    addr_err = (rom_a_o[1:0] != 2'b00) || ((rom_a_o >> (ROM_AW + 2)) != 32'h0);
    rom_data = addr_err ? 32'h0 : rom_inst_i;

    if (dbg_gnt_o || !dbg_req_i) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q == MaxWait) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q  <= 1'b0;
      dbg_valid_q <= 1'b0;
      if_inst_q   <= 32'h0;
      dbg_inst_q  <= 32'h0;
      if_err_q    <= 1'b0;
      dbg_err_q   <= 1'b0;
      wait_cnt_q  <= 4'd0;
    end else begin
      if_valid_q  <= if_gnt_o;
      dbg_valid_q <= dbg_gnt_o;
      wait_cnt_q  <= wait_cnt_d;
      if (if_gnt_o) begin
        if_inst_q <= rom_data;
        if_err_q  <= addr_err;
      end
      if (dbg_gnt_o) begin
        dbg_inst_q <= rom_data;
        dbg_err_q  <= addr_err;
      end
    end
  end

  // A flush kills the response to the grant made in the previous cycle.
  assign if_valid_o  = if_valid_q & ~if_flush_i;
  assign dbg_valid_o = dbg_valid_q;
  assign if_inst_o   = if_inst_q;
  assign if_err_o    = if_err_q;
  assign dbg_inst_o  = dbg_inst_q;
  assign dbg_err_o   = dbg_err_q;

endmodule
